// File: rtl/bus_pkg.sv
// Shared types and constants for the host-to-external bus lane sequencer.
// Memory port width codes give log2 of the port width in bytes.
package bus_pkg;

  localparam int unsigned BusDw = 64;

  localparam int unsigned Mws8  = 0;
  localparam int unsigned Mws16 = 1;
  localparam int unsigned Mws32 = 2;
  localparam int unsigned Mws64 = 3;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StBeat,
    StGap,
    StDone
  } state_e;

endpackage

// File: rtl/bus_lane_shift.sv
// Combinational byte-lane shifter.
// Shifts down to extract write beats, or up to place read beats.
module bus_lane_shift #(
  parameter int unsigned DW = 64,
  parameter int unsigned OW = 3
) (
  input  logic [DW-1:0] src,
  input  logic [OW-1:0] amt,
  input  logic          up,
  output logic [DW-1:0] res
);

  always_comb begin
    res = up ? (src << {amt, 3'b000}) : (src >> {amt, 3'b000});
  end

endmodule

// File: rtl/bus_lane_sequencer.sv
// Splits one aligned host transfer into narrow external beats.
// Steers write bytes onto low lanes and gathers read bytes back into natural lanes.
module bus_lane_sequencer
  import bus_pkg::*;
#(
  parameter int unsigned DW  = BusDw,
  parameter int unsigned OW  = 3,
  parameter int unsigned TMO = 255
) (
  input  logic            sys_clk,
  input  logic            resetl,
  input  logic            req,
  input  logic            rd,
  input  logic [OW-1:0]   off,
  input  logic [OW:0]     size,
  input  logic [OW:0]     mws,
  input  logic [DW-1:0]   wdata,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [DW-1:0]   rdata,
  output logic            ext_cyc,
  output logic            ext_we,
  output logic [OW-1:0]   ext_ba,
  output logic [DW/8-1:0] ext_den,
  output logic [DW-1:0]   ext_wdata,
  input  logic [DW-1:0]   ext_rdata,
  input  logic            ext_ack
);

  localparam int unsigned BL = DW / 8;
  localparam int unsigned TW = (TMO > 1) ? $clog2(TMO + 1) : 1;

  state_e        state_q, state_d;
  logic          fail;
  logic          rd_q;
  logic [OW-1:0] off_q;
  logic [OW:0]   size_q, pb_q, k_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic [TW-1:0] tmo_q;
  logic          accept, ack_ok, last, misaligned, tmo_hit, in_beat;
  logic [BL-1:0] low_lanes;
  logic [DW-1:0] low_bits, merge_bits, wr_shifted, rd_placed, rd_masked;
  logic          busy_d, done_d, err_d, cyc_d, we_d;
  logic [OW-1:0] ba_d;
  logic [BL-1:0] den_d;
  logic [DW-1:0] wdat_d;

  assign accept     = (state_q == StIdle) && req;
  assign ack_ok     = (state_q == StBeat) && ext_cyc && ext_ack;
  assign misaligned = (off_q & OW'((1 << size_q) - 1)) != '0;
  assign last       = k_q == (OW + 1)'((1 << (size_q - pb_q)) - 1);
  assign tmo_hit    = (TMO != 0) && (tmo_q == TW'(TMO - 1));
  assign rd_masked  = ext_rdata & low_bits;
  assign merge_bits = low_bits << {ext_ba, 3'b000};
  assign rdata      = rdata_q;

  // Beat lanes 0..2^pb-1, as a lane mask and as a bit mask.
  always_comb begin
    low_lanes = BL'((1 << (1 << pb_q)) - 1);
    low_bits  = '0;
    for (int i = 0; i < BL; i++) begin
      low_bits[i*8 +: 8] = {8{low_lanes[i]}};
    end
  end

  bus_lane_shift #(.DW(DW), .OW(OW)) u_wr_shift (
    .src (wdata_q),
    .amt (ba_d),
    .up  (1'b0),
    .res (wr_shifted)
  );

  bus_lane_shift #(.DW(DW), .OW(OW)) u_rd_shift (
    .src (rd_masked),
    .amt (ext_ba),
    .up  (1'b1),
    .res (rd_placed)
  );

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fail    = 1'b0;
    unique case (state_q)
      StIdle:  if (req) state_d = StCheck;
      StCheck: begin
        state_d = misaligned ? StDone : StBeat;
        fail    = misaligned;
      end
      StBeat: begin
        if (ack_ok) begin
          state_d = last ? StDone : StGap;
        end else if (tmo_hit) begin
          state_d = StDone;
          fail    = 1'b1;
        end
      end
      StGap:   state_d = StBeat;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight off a flop.
  always_comb begin
    in_beat = state_d == StBeat;
    busy_d  = state_d != StIdle;
    done_d  = state_d == StDone;
    err_d   = fail;
    cyc_d   = in_beat;
    we_d    = in_beat && !rd_q;
    ba_d    = '0;
    den_d   = '0;
    wdat_d  = '0;
    if (in_beat) begin
      ba_d = off_q + OW'(k_q << pb_q);
      if (!rd_q) begin
        den_d  = low_lanes;
        wdat_d = wr_shifted & low_bits;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ext_cyc   <= 1'b0;
      ext_we    <= 1'b0;
      ext_ba    <= '0;
      ext_den   <= '0;
      ext_wdata <= '0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      ext_cyc   <= cyc_d;
      ext_we    <= we_d;
      ext_ba    <= ba_d;
      ext_den   <= den_d;
      ext_wdata <= wdat_d;
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      rd_q    <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      pb_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      k_q     <= '0;
      tmo_q   <= '0;
    end else begin
      if (accept) begin
        rd_q    <= rd;
        off_q   <= off;
        size_q  <= size;
        pb_q    <= (size < mws) ? size : mws;
        wdata_q <= wdata;
        rdata_q <= '0;
        k_q     <= '0;
      end else if (ack_ok && !last) begin
        k_q <= k_q + (OW + 1)'(1);
      end
      if (ack_ok && rd_q) begin
        rdata_q <= (rdata_q & ~merge_bits) | (rd_placed & merge_bits);
      end
      // Counter restarts whenever a beat is (re)entered.
      if (state_q != StBeat) begin
        tmo_q <= '0;
      end else if (!ack_ok) begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_lane_sequencer.sv
// Directed bench for bus_lane_sequencer on a 64-bit port with a short beat timeout.
module tb_bus_lane_sequencer;

  logic        sys_clk = 1'b0;
  logic        resetl;
  logic        req, rd;
  logic [2:0]  off;
  logic [3:0]  size, mws;
  logic [63:0] wdata;
  logic        busy, done, err;
  logic [63:0] rdata;
  logic        ext_cyc, ext_we;
  logic [2:0]  ext_ba;
  logic [7:0]  ext_den;
  logic [63:0] ext_wdata, ext_rdata;
  logic        ext_ack;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] beat_data [4];
  logic [2:0]  ba_log [$];
  logic [7:0]  den_or;
  logic        we_or;
  logic [63:0] first_wdata;
  int          cycles, cyc_hi;
  bit          got_done;

  always #5 sys_clk = ~sys_clk;

  bus_lane_sequencer #(.DW(64), .OW(3), .TMO(4)) dut (
    .sys_clk   (sys_clk),
    .resetl    (resetl),
    .req       (req),
    .rd        (rd),
    .off       (off),
    .size      (size),
    .mws       (mws),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .ext_cyc   (ext_cyc),
    .ext_we    (ext_we),
    .ext_ba    (ext_ba),
    .ext_den   (ext_den),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [63:0] ba_at(input int i);
    return (i < ba_log.size()) ? 64'(ba_log[i]) : 64'hF;
  endfunction

  task automatic start(input logic r, input logic [2:0] o, input logic [3:0] s,
                       input logic [3:0] m, input logic [63:0] wd);
    rd    = r;
    off   = o;
    size  = s;
    mws   = m;
    wdata = wd;
    req   = 1'b1;
    ba_log.delete();
    den_or      = '0;
    we_or       = 1'b0;
    first_wdata = '0;
  endtask

  // Bench memory: answers each ext_cyc cycle with the next beat_data word.
  task automatic run(input bit hold_req, output int n_cyc, output int n_hi, output bit seen);
    int beat = 0;
    n_cyc = 0;
    n_hi  = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      n_cyc++;
      req = hold_req;
      if (ext_cyc) begin
        if (n_hi == 0) first_wdata = ext_wdata;
        ba_log.push_back(ext_ba);
        den_or   |= ext_den;
        we_or    |= ext_we;
        ext_rdata = beat_data[beat % 4];
        beat++;
        n_hi++;
      end else begin
        ext_rdata = '0;
      end
      if (done) seen = 1'b1;
    end
    check_eq("done_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    resetl    = 1'b0;
    req       = 1'b0;
    rd        = 1'b0;
    off       = '0;
    size      = '0;
    mws       = '0;
    wdata     = '0;
    ext_rdata = '0;
    ext_ack   = 1'b1;
    beat_data = '{64'h0, 64'h0, 64'h0, 64'h0};
    tick();
    tick();
    check_eq("rst_ctrl", 64'({busy, done, err, ext_cyc, ext_we}), 64'd0);
    check_eq("rst_ba_den", 64'({ext_ba, ext_den}), 64'd0);
    check_eq("rst_wdata", ext_wdata, 64'd0);
    check_eq("rst_rdata", rdata, 64'd0);
    resetl = 1'b1;
    tick();

    // 1: full-width write, one beat
    start(1'b0, 3'd0, 4'd3, 4'd3, 64'h0123_4567_89AB_CDEF);
    run(1'b0, cycles, cyc_hi, got_done);
    check_eq("t1_cycles", 64'(cycles), 64'd3);
    check_eq("t1_beats", 64'(cyc_hi), 64'd1);
    check_eq("t1_den", 64'(den_or), 64'hFF);
    check_eq("t1_wdata", first_wdata, 64'h0123_4567_89AB_CDEF);
    check_eq("t1_we", 64'(we_or), 64'd1);
    check_eq("t1_err", 64'(err), 64'd0);
    tick();
    check_eq("t1_idle", 64'({busy, done}), 64'd0);

    // 2: 32-bit read over an 8-bit port, junk on unused lanes
    beat_data = '{64'hFFFF_FFFF_FFFF_FF11, 64'hFFFF_FFFF_FFFF_FF22,
                  64'hFFFF_FFFF_FFFF_FF33, 64'hFFFF_FFFF_FFFF_FF44};
    start(1'b1, 3'd4, 4'd2, 4'd0, 64'h0);
    run(1'b0, cycles, cyc_hi, got_done);
    check_eq("t2_cycles", 64'(cycles), 64'd9);
    check_eq("t2_beats", 64'(cyc_hi), 64'd4);
    for (int i = 0; i < 4; i++) check_eq("t2_ba", ba_at(i), 64'(4 + i));
    check_eq("t2_den_we", 64'({den_or, we_or}), 64'd0);
    check_eq("t2_err", 64'(err), 64'd0);
    check_eq("t2_rdata", rdata, 64'h4433_2211_0000_0000);
    tick();
    tick();
    check_eq("t2_rdata_hold", rdata, 64'h4433_2211_0000_0000);

    // 7: 16-bit read on a wide port, rdata cleared by the new request
    beat_data = '{64'h1234_5678_9ABC_BBAA, 64'h0, 64'h0, 64'h0};
    start(1'b1, 3'd6, 4'd1, 4'd3, 64'h0);
    run(1'b0, cycles, cyc_hi, got_done);
    check_eq("t7_cycles", 64'(cycles), 64'd3);
    check_eq("t7_ba", ba_at(0), 64'd6);
    check_eq("t7_rdata", rdata, 64'hBBAA_0000_0000_0000);
    tick();

    // 4: misaligned
    start(1'b0, 3'd3, 4'd1, 4'd1, 64'hFFFF);
    run(1'b0, cycles, cyc_hi, got_done);
    check_eq("t4_cycles", 64'(cycles), 64'd2);
    check_eq("t4_no_cyc", 64'(cyc_hi), 64'd0);
    check_eq("t4_err", 64'(err), 64'd1);
    tick();

    // 5: timeout with req held high throughout
    ext_ack = 1'b0;
    start(1'b0, 3'd0, 4'd3, 4'd3, 64'h55);
    run(1'b1, cycles, cyc_hi, got_done);
    req = 1'b0;
    check_eq("t5_cycles", 64'(cycles), 64'd6);
    check_eq("t5_cyc_hi", 64'(cyc_hi), 64'd4);
    check_eq("t5_err", 64'(err), 64'd1);
    check_eq("t5_cyc_low", 64'(ext_cyc), 64'd0);
    tick();
    check_eq("t5_idle", 64'(busy), 64'd0);
    tick();
    check_eq("t5_no_queue", 64'({busy, ext_cyc}), 64'd0);
    ext_ack = 1'b1;

    // 6: reset during the second of four read beats
    beat_data = '{64'hA1, 64'hA2, 64'hA3, 64'hA4};
    start(1'b1, 3'd4, 4'd2, 4'd0, 64'h0);
    tick();
    req = 1'b0;
    tick();
    check_eq("t6_beat0", 64'(ext_cyc), 64'd1);
    ext_rdata = beat_data[0];
    tick();
    check_eq("t6_gap", 64'(ext_cyc), 64'd0);
    ext_rdata = '0;
    tick();
    check_eq("t6_beat1", 64'({ext_cyc, ext_ba}), 64'h0D);
    resetl = 1'b0;
    #1;
    check_eq("t6_async", 64'({ext_cyc, busy, done}), 64'd0);
    tick();
    check_eq("t6_no_done", 64'(done), 64'd0);
    check_eq("t6_rdata", rdata, 64'd0);
    #2;
    resetl = 1'b1;
    tick();

    // 3: 16-bit write after reset
    start(1'b0, 3'd2, 4'd1, 4'd1, 64'h0000_0000_BEEF_0000);
    run(1'b0, cycles, cyc_hi, got_done);
    check_eq("t3_cycles", 64'(cycles), 64'd3);
    check_eq("t3_ba", ba_at(0), 64'd2);
    check_eq("t3_den", 64'(den_or), 64'h03);
    check_eq("t3_wdata", first_wdata, 64'h0000_0000_0000_BEEF);
    check_eq("t3_err", 64'(err), 64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
